// File: rtl/decode_issue_queue_pkg.sv
// Shared decode/issue definitions: default widths and the decoded-bundle layout
// that decode packs once before handing it to the issue queue.
package decode_issue_queue_pkg;

  localparam int WORD       = 32;
  localparam int ADDR_WIDTH = 4;
  localparam int PAYLOAD_W  = 3 * WORD;

  typedef struct packed {
    logic [PAYLOAD_W-1:0]  payload;
    logic [ADDR_WIDTH-1:0] src1_addr;
    logic                  src1_used;
    logic [ADDR_WIDTH-1:0] src2_addr;
    logic                  src2_used;
    logic [ADDR_WIDTH-1:0] dest;
    logic                  is_load;
  } issue_entry_t;

endpackage

// File: rtl/decode_issue_queue_hazard_check.sv
// Load-use interlock: flags a head entry that reads the register written by
// the load that issued on the previous cycle.
module decode_issue_queue_hazard_check #(
  parameter int ADDR_WIDTH = decode_issue_queue_pkg::ADDR_WIDTH
) (
  input  logic                  last_load_i,
  input  logic [ADDR_WIDTH-1:0] last_dest_i,
  input  logic [ADDR_WIDTH-1:0] src1_addr_i,
  input  logic                  src1_used_i,
  input  logic [ADDR_WIDTH-1:0] src2_addr_i,
  input  logic                  src2_used_i,
  output logic                  hazard_o
);

  logic src1_hit;
  logic src2_hit;

  assign src1_hit = src1_used_i && (src1_addr_i == last_dest_i);
  assign src2_hit = src2_used_i && (src2_addr_i == last_dest_i);
  assign hazard_o = last_load_i && (src1_hit || src2_hit);

endmodule

// File: rtl/decode_issue_queue.sv
// Decode-to-execute issue buffer: DEPTH-entry in-order circular queue with a
// one-cycle load-use bubble, flush, occupancy and a saturating stall counter.
module decode_issue_queue #(
  parameter int PAYLOAD_W  = decode_issue_queue_pkg::PAYLOAD_W,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = decode_issue_queue_pkg::ADDR_WIDTH,
  parameter int CNT_W      = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [PAYLOAD_W-1:0]         in_payload_i,
  input  logic [ADDR_WIDTH-1:0]        in_src1_addr_i,
  input  logic                         in_src1_used_i,
  input  logic [ADDR_WIDTH-1:0]        in_src2_addr_i,
  input  logic                         in_src2_used_i,
  input  logic [ADDR_WIDTH-1:0]        in_dest_addr_i,
  input  logic                         in_is_load_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [PAYLOAD_W-1:0]         out_payload_o,
  output logic [ADDR_WIDTH-1:0]        out_dest_addr_o,
  output logic                         out_is_load_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [CNT_W-1:0]             stall_count_o
);

  localparam int                PTR_W = $clog2(DEPTH);
  localparam int                OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0]  FULL  = OCC_W'(DEPTH);

  typedef struct packed {
    logic [PAYLOAD_W-1:0]  payload;
    logic [ADDR_WIDTH-1:0] src1_addr;
    logic                  src1_used;
    logic [ADDR_WIDTH-1:0] src2_addr;
    logic                  src2_used;
    logic [ADDR_WIDTH-1:0] dest;
    logic                  is_load;
  } entry_t;

  entry_t                mem_q [DEPTH];
  entry_t                in_entry;
  entry_t                head;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      count_q, count_d;
  logic                  last_load_q, last_load_d;
  logic [ADDR_WIDTH-1:0] last_dest_q, last_dest_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic                  hazard;
  logic                  stall;
  logic                  push;
  logic                  pop;

  assign in_entry = '{payload:   in_payload_i,
                      src1_addr: in_src1_addr_i,
                      src1_used: in_src1_used_i,
                      src2_addr: in_src2_addr_i,
                      src2_used: in_src2_used_i,
                      dest:      in_dest_addr_i,
                      is_load:   in_is_load_i};
  assign head = mem_q[rd_ptr_q];

  decode_issue_queue_hazard_check #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_hazard_check (
    .last_load_i (last_load_q),
    .last_dest_i (last_dest_q),
    .src1_addr_i (head.src1_addr),
    .src1_used_i (head.src1_used),
    .src2_addr_i (head.src2_addr),
    .src2_used_i (head.src2_used),
    .hazard_o    (hazard)
  );

  // Ready depends only on occupancy, so a full queue refuses a push even when
  // the head drains in the same cycle.
  assign in_ready_o  = (count_q != FULL);
  assign out_valid_o = (count_q != '0) && !hazard;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  assign stall       = (count_q != '0) && hazard;

  assign out_payload_o   = head.payload;
  assign out_dest_addr_o = head.dest;
  assign out_is_load_o   = head.is_load;
  assign count_o         = count_q;
  assign stall_count_o   = stall_cnt_q;

  // NOTE: payload storage has no reset; entries are only observed through
  // count_q, so clearing them would buy nothing.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

  // NOTE: every _d gets its hold value first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    last_load_d = last_load_q;
    last_dest_d = last_dest_q;
    stall_cnt_d = stall_cnt_q;

    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    if (flush_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      last_load_d = 1'b0;
    end else begin
      // A blocked cycle has no pop, which is what limits the bubble to one.
      last_load_d = pop && head.is_load;
      if (pop) begin
        rd_ptr_d    = rd_ptr_q + PTR_W'(1);
        last_dest_d = head.dest;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + OCC_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - OCC_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of the others.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_load_q <= 1'b0;
      last_dest_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      last_load_q <= last_load_d;
      last_dest_q <= last_dest_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_decode_issue_queue.sv
// Self-checking bench for decode_issue_queue: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_decode_issue_queue;

  localparam int PAYLOAD_W  = 96;
  localparam int DEPTH      = 4;
  localparam int ADDR_WIDTH = 4;
  // A narrow stall counter keeps the saturation scenario short.
  localparam int CNT_W      = 8;
  localparam int OCC_W      = $clog2(DEPTH + 1);
  localparam int STALL_MAX  = (1 << CNT_W) - 1;

  typedef struct {
    logic [PAYLOAD_W-1:0]  payload;
    logic [ADDR_WIDTH-1:0] src1;
    logic                  src1_used;
    logic [ADDR_WIDTH-1:0] src2;
    logic                  src2_used;
    logic [ADDR_WIDTH-1:0] dest;
    logic                  is_load;
  } ent_t;

  logic                  clk_i = 1'b0;
  logic                  reset_i, flush_i, in_valid_i, out_ready_i;
  ent_t                  cur;
  logic                  in_ready_o, out_valid_o, out_is_load_o;
  logic [PAYLOAD_W-1:0]  out_payload_o;
  logic [ADDR_WIDTH-1:0] out_dest_addr_o;
  logic [OCC_W-1:0]      count_o;
  logic [CNT_W-1:0]      stall_count_o;

  always #5 clk_i = ~clk_i;

  decode_issue_queue #(
    .PAYLOAD_W (PAYLOAD_W), .DEPTH (DEPTH), .ADDR_WIDTH (ADDR_WIDTH), .CNT_W (CNT_W)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .flush_i         (flush_i),
    .in_valid_i      (in_valid_i),
    .in_ready_o      (in_ready_o),
    .in_payload_i    (cur.payload),
    .in_src1_addr_i  (cur.src1),
    .in_src1_used_i  (cur.src1_used),
    .in_src2_addr_i  (cur.src2),
    .in_src2_used_i  (cur.src2_used),
    .in_dest_addr_i  (cur.dest),
    .in_is_load_i    (cur.is_load),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .out_payload_o   (out_payload_o),
    .out_dest_addr_o (out_dest_addr_o),
    .out_is_load_o   (out_is_load_o),
    .count_o         (count_o),
    .stall_count_o   (stall_count_o)
  );

  // Reference model: an ordered list of pending bundles plus the identity of
  // the last issued instruction.
  ent_t                  m_q[$];
  bit                    m_last_load;
  logic [ADDR_WIDTH-1:0] m_last_dest;
  int                    m_stall;
  int                    n_cmp = 0;
  int                    n_fail = 0;

  function automatic bit m_hazard();
    if (m_q.size() == 0 || !m_last_load) return 1'b0;
    return (m_q[0].src1_used && m_q[0].src1 == m_last_dest) ||
           (m_q[0].src2_used && m_q[0].src2 == m_last_dest);
  endfunction

  function automatic bit m_valid();
    return (m_q.size() != 0) && !m_hazard();
  endfunction

  function automatic bit m_ready();
    return m_q.size() != DEPTH;
  endfunction

  function automatic ent_t rand_ent(int amax);
    ent_t e;
    e.payload   = {$urandom, $urandom, $urandom};
    e.src1      = ADDR_WIDTH'($urandom_range(amax));
    e.src2      = ADDR_WIDTH'($urandom_range(amax));
    e.dest      = ADDR_WIDTH'($urandom_range(amax));
    e.src1_used = 1'($urandom_range(1));
    e.src2_used = 1'($urandom_range(1));
    e.is_load   = 1'($urandom_range(1));
    return e;
  endfunction

  function automatic ent_t mk(int ld, int dest, int s1, int s1u, int s2, int s2u);
    ent_t e;
    e.payload   = {$urandom, $urandom, $urandom};
    e.is_load   = 1'(ld);
    e.dest      = ADDR_WIDTH'(dest);
    e.src1      = ADDR_WIDTH'(s1);
    e.src1_used = 1'(s1u);
    e.src2      = ADDR_WIDTH'(s2);
    e.src2_used = 1'(s2u);
    return e;
  endfunction

  // Advance one clock (inputs already driven at the falling edge) and move the
  // model forward by the same cycle.
  task automatic tick();
    bit   hz, pop, push;
    ent_t e;
    hz   = m_hazard();
    pop  = m_valid() && out_ready_i;
    push = in_valid_i && m_ready();
    e    = cur;
    @(posedge clk_i);
    if (reset_i) begin
      m_q.delete();
      m_last_load = 1'b0;
      m_stall     = 0;
    end else begin
      if (hz && m_stall < STALL_MAX) m_stall++;
      if (flush_i) begin
        m_q.delete();
        m_last_load = 1'b0;
      end else begin
        m_last_load = pop && m_q[0].is_load;
        if (pop) begin
          m_last_dest = m_q[0].dest;
          void'(m_q.pop_front());
        end
        if (push) m_q.push_back(e);
      end
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    reset_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b1; out_ready_i = 1'b1;
    cur = rand_ent(15);
    tick();
    tick();
    reset_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    n_cmp++; if (count_o !== '0)         begin n_fail++; $display("FAIL reset_count: got %0d want 0", count_o); end
    n_cmp++; if (out_valid_o !== 1'b0)   begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid_o); end
    n_cmp++; if (in_ready_o !== 1'b1)    begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready_o); end
    n_cmp++; if (stall_count_o !== '0)   begin n_fail++; $display("FAIL reset_stall: got %0d want 0", stall_count_o); end
  endtask

  task automatic test_fill_drain();
    ent_t a[4];
    out_ready_i = 1'b0; in_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a[i] = mk(0, $urandom_range(15), $urandom_range(15), 1, $urandom_range(15), 1);
      cur = a[i];
      tick();
      n_cmp++; if (count_o !== OCC_W'(i + 1)) begin n_fail++; $display("FAIL fill_count%0d: got %0d want %0d", i, count_o, i + 1); end
    end
    n_cmp++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b want 0", in_ready_o); end
    // Offer a fifth bundle while popping: a full queue must still refuse it.
    cur = mk(0, 1, 2, 0, 3, 0);
    out_ready_i = 1'b1;
    n_cmp++; if (out_valid_o !== 1'b1 || out_payload_o !== a[0].payload) begin
      n_fail++; $display("FAIL drain0: got v=%b %h want v=1 %h", out_valid_o, out_payload_o, a[0].payload); end
    tick();
    n_cmp++; if (count_o !== OCC_W'(3)) begin n_fail++; $display("FAIL full_no_push: got %0d want 3", count_o); end
    in_valid_i = 1'b0;
    for (int i = 1; i < 4; i++) begin
      n_cmp++; if (out_valid_o !== 1'b1 || out_payload_o !== a[i].payload) begin
        n_fail++; $display("FAIL drain%0d: got v=%b %h want v=1 %h", i, out_valid_o, out_payload_o, a[i].payload); end
      tick();
    end
    n_cmp++; if (count_o !== '0 || out_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL drained: got count=%0d v=%b want 0 0", count_o, out_valid_o); end
  endtask

  // Queue the bundles with execute stalled, then release and compare the
  // per-cycle issue pattern ('1' = issue, '0' = bubble).
  task automatic run_issue_pattern(input string name, input ent_t seq[$], input bit pat[$], input int bubbles);
    int s0;
    int k;
    out_ready_i = 1'b0; in_valid_i = 1'b1;
    foreach (seq[i]) begin cur = seq[i]; tick(); end
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    s0 = m_stall;
    k  = 0;
    foreach (pat[i]) begin
      n_cmp++; if (out_valid_o !== pat[i]) begin
        n_fail++; $display("FAIL %s_valid_c%0d: got %b want %b", name, i, out_valid_o, pat[i]); end
      if (pat[i]) begin
        n_cmp++; if (out_payload_o !== seq[k].payload) begin
          n_fail++; $display("FAIL %s_payload_c%0d: got %h want %h", name, i, out_payload_o, seq[k].payload); end
        k++;
      end
      tick();
    end
    n_cmp++; if (int'(stall_count_o) !== s0 + bubbles) begin
      n_fail++; $display("FAIL %s_stall: got %0d want %0d", name, stall_count_o, s0 + bubbles); end
  endtask

  task automatic test_load_use();
    run_issue_pattern("load_use", '{mk(1, 3, 0, 0, 0, 0), mk(0, 5, 3, 1, 9, 0)}, '{1, 0, 1}, 1);
    run_issue_pattern("dep_loads", '{mk(1, 3, 0, 0, 0, 0), mk(1, 5, 3, 1, 0, 0), mk(0, 6, 1, 0, 5, 1)},
                      '{1, 0, 1, 0, 1}, 2);
  endtask

  task automatic test_unused_src();
    run_issue_pattern("unused_src", '{mk(1, 3, 0, 0, 0, 0), mk(0, 5, 7, 1, 3, 0)}, '{1, 1}, 0);
  endtask

  task automatic test_flush();
    ent_t x, y;
    int   s0;
    out_ready_i = 1'b0; in_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin cur = mk(0, i, i, 1, i, 1); tick(); end
    n_cmp++; if (count_o !== OCC_W'(3)) begin n_fail++; $display("FAIL pre_flush_count: got %0d want 3", count_o); end
    s0 = m_stall;
    x = mk(0, 1, 1, 0, 1, 0);
    cur = x; flush_i = 1'b1;
    tick();
    flush_i = 1'b0; in_valid_i = 1'b0;
    n_cmp++; if (count_o !== '0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL flush_state: got count=%0d v=%b rdy=%b want 0 0 1", count_o, out_valid_o, in_ready_o); end
    n_cmp++; if (int'(stall_count_o) !== s0) begin n_fail++; $display("FAIL flush_stall: got %0d want %0d", stall_count_o, s0); end
    y = mk(0, 2, 2, 0, 2, 0);
    cur = y; in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    n_cmp++; if (out_valid_o !== 1'b1 || out_payload_o !== y.payload) begin
      n_fail++; $display("FAIL flush_next: got v=%b %h want v=1 %h", out_valid_o, out_payload_o, y.payload); end
    tick();
    n_cmp++; if (count_o !== '0) begin n_fail++; $display("FAIL flush_discard: got %0d want 0", count_o); end
  endtask

  task automatic test_stream_wrap();
    localparam int N = 2 * DEPTH + 3;
    ent_t p[N + 1];
    foreach (p[i]) p[i] = mk(0, i % 16, 0, 0, 0, 0);
    out_ready_i = 1'b1; in_valid_i = 1'b1;
    cur = p[0];
    tick();
    for (int i = 0; i < N; i++) begin
      n_cmp++; if (count_o !== OCC_W'(1) || out_valid_o !== 1'b1 || out_payload_o !== p[i].payload) begin
        n_fail++; $display("FAIL stream%0d: got c=%0d v=%b %h want c=1 v=1 %h", i, count_o, out_valid_o, out_payload_o, p[i].payload); end
      cur = p[i + 1];
      tick();
    end
    in_valid_i = 1'b0;
    n_cmp++; if (out_payload_o !== p[N].payload) begin
      n_fail++; $display("FAIL stream_last: got %h want %h", out_payload_o, p[N].payload); end
    tick();
    n_cmp++; if (count_o !== '0) begin n_fail++; $display("FAIL stream_empty: got %0d want 0", count_o); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      flush_i     = ($urandom_range(15) == 0);
      in_valid_i  = ($urandom_range(3) != 0);
      out_ready_i = ($urandom_range(3) != 0);
      cur         = rand_ent(3);
      n_cmp++; if (count_o !== OCC_W'(m_q.size()) || in_ready_o !== m_ready() || out_valid_o !== m_valid()) begin
        n_fail++; $display("FAIL rand_ctrl_c%0d: got c=%0d rdy=%b v=%b want c=%0d rdy=%b v=%b",
                           c, count_o, in_ready_o, out_valid_o, m_q.size(), m_ready(), m_valid()); end
      n_cmp++; if (int'(stall_count_o) !== m_stall) begin
        n_fail++; $display("FAIL rand_stall_c%0d: got %0d want %0d", c, stall_count_o, m_stall); end
      if (m_q.size() != 0) begin
        n_cmp++; if (out_payload_o !== m_q[0].payload || out_dest_addr_o !== m_q[0].dest || out_is_load_o !== m_q[0].is_load) begin
          n_fail++; $display("FAIL rand_head_c%0d: got %h d=%0d l=%b want %h d=%0d l=%b", c, out_payload_o,
                             out_dest_addr_o, out_is_load_o, m_q[0].payload, m_q[0].dest, m_q[0].is_load); end
      end
      tick();
    end
    flush_i = 1'b0;
  endtask

  task automatic test_saturation();
    in_valid_i = 1'b1; out_ready_i = 1'b1;
    for (int c = 0; c < 2 * STALL_MAX + 60; c++) begin
      cur = mk(1, 3, 3, 1, 0, 0);
      tick();
      if (c == 100) begin
        n_cmp++; if (int'(stall_count_o) !== m_stall) begin
          n_fail++; $display("FAIL sat_mid: got %0d want %0d", stall_count_o, m_stall); end
      end
    end
    n_cmp++; if (int'(stall_count_o) !== STALL_MAX) begin
      n_fail++; $display("FAIL sat_hold: got %0d want %0d", stall_count_o, STALL_MAX); end
  endtask

  task automatic test_reset_mid();
    ent_t z;
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0; in_valid_i = 1'b0;
    n_cmp++; if (count_o !== '0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || stall_count_o !== '0) begin
      n_fail++; $display("FAIL mid_reset: got c=%0d v=%b rdy=%b st=%0d want 0 0 1 0",
                         count_o, out_valid_o, in_ready_o, stall_count_o); end
    z = mk(1, 3, 3, 1, 3, 1);
    cur = z; in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    n_cmp++; if (out_valid_o !== 1'b1 || out_payload_o !== z.payload) begin
      n_fail++; $display("FAIL post_reset_push: got v=%b %h want v=1 %h", out_valid_o, out_payload_o, z.payload); end
    tick();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_load_use();
    test_unused_src();
    test_flush();
    test_stream_wrap();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
